// File: rtl/spi_display_rx.sv
// Display-end SPI mode-0 receiver: synchronizes the link, deserializes MSB-first bytes tagged with dc into a FIFO.
// First entry appears SYNC_STAGES+2 clk after the 8th sclk rise is sampled; a full FIFO drops bytes (sticky overflow) unless popped that cycle.
module spi_display_rx #(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        spi_sclk,
   input  logic                        spi_sdo,
   input  logic                        dc,
   input  logic                        csn,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [7:0]                  rx_data,
   output logic                        rx_dc,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        frame_err,
   input  logic                        err_clr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, sdo_sync, dc_sync, csn_sync;
   logic                   sclk_prev, rise_q, sdo_q, dc_q, csn_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclk_sync <= '0;
         sdo_sync  <= '0;
         dc_sync   <= '0;
         csn_sync  <= '1;
         sclk_prev <= 1'b0;
         rise_q    <= 1'b0;
         sdo_q     <= 1'b0;
         dc_q      <= 1'b0;
         csn_q     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], spi_sdo};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         // Rise event registered together with the data it qualifies.
         rise_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
         sdo_q     <= sdo_sync[SYNC_STAGES-1];
         dc_q      <= dc_sync[SYNC_STAGES-1];
         csn_q     <= csn_sync[SYNC_STAGES-1];
      end
   end

   state_t      state, state_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shifter, shifter_nxt;
   logic        wr_vld, wr_vld_nxt;
   logic [7:0]  wr_dat, wr_dat_nxt;
   logic        wr_dc, wr_dc_nxt;
   logic        frame_err_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shifter   <= '0;
         wr_vld    <= 1'b0;
         wr_dat    <= '0;
         wr_dc     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shifter   <= shifter_nxt;
         wr_vld    <= wr_vld_nxt;
         wr_dat    <= wr_dat_nxt;
         wr_dc     <= wr_dc_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shifter_nxt   = shifter;
      wr_vld_nxt    = 1'b0;
      wr_dat_nxt    = wr_dat;
      wr_dc_nxt     = wr_dc;
      frame_err_nxt = frame_err & ~err_clr;
      case (state)
         IDLE: begin
            if (!csn_q) begin
               bit_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            // csn high takes priority over a coincident rise.
            if (csn_q) begin
               if (bit_cnt != 3'd0)
                  frame_err_nxt = 1'b1;
               bit_cnt_nxt = '0;
               state_nxt   = IDLE;
            end else if (rise_q) begin
               shifter_nxt = {shifter[6:0], sdo_q};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  wr_vld_nxt = 1'b1;
                  wr_dat_nxt = {shifter[6:0], sdo_q};
                  wr_dc_nxt  = dc_q;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic [7:0]    mem_dat [FIFO_DEPTH];
   logic          mem_dc  [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, push_ok, ovf_set;

   assign rx_valid = (fifo_level != '0);
   assign rx_data  = mem_dat[rd_ptr];
   assign rx_dc    = mem_dc[rd_ptr];
   assign full     = (fifo_level == FULL_LVL);
   assign pop      = rx_valid & rx_ready;
   // At full the write slot is the one being popped, so push+pop is safe.
   assign push_ok  = wr_vld & (~full | pop);
   assign ovf_set  = wr_vld & full & ~pop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_dat[i] <= '0;
            mem_dc[i]  <= 1'b0;
         end
      end else begin
         if (push_ok) begin
            mem_dat[wr_ptr] <= wr_dat;
            mem_dc[wr_ptr]  <= wr_dc;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + (PW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (PW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
         overflow <= ovf_set | (overflow & ~err_clr);
      end
   end

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed bench for spi_display_rx: byte framing, latency, FIFO full/overflow, framing error, mid-frame reset.
module tb_spi_display_rx;

   logic       clk = 1'b0;
   logic       resetn, spi_sclk, spi_sdo, dc, csn, rx_ready, err_clr;
   logic       rx_valid, rx_dc, overflow, frame_err;
   logic [7:0] rx_data;
   logic [4:0] fifo_level;

   int checks = 0;
   int errors = 0;

   spi_display_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_sdo(spi_sdo),
      .dc(dc), .csn(csn), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_dc(rx_dc), .fifo_level(fifo_level),
      .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic spi_bit(input logic b);
      cycles(1);
      spi_sdo = b;
      cycles(2);
      spi_sclk = 1'b1;
      cycles(3);
      spi_sclk = 1'b0;
   endtask

   // mode 0: plain, 1: pulse rx_ready on the push cycle, 2: check first-entry latency
   task automatic send_byte(input logic [7:0] b, input int mode);
      for (int i = 7; i >= 1; i--) spi_bit(b[i]);
      cycles(1);
      spi_sdo = b[0];
      cycles(2);
      spi_sclk = 1'b1;
      @(posedge clk);      // first edge sampling the 8th rise
      cycles(3);
      if (mode == 2) check("latency_pre", rx_valid, 1'b0);
      if (mode == 1) rx_ready = 1'b1;
      cycles(1);
      if (mode == 2) check("latency_at4", rx_valid, 1'b1);
      rx_ready = 1'b0;
      spi_sclk = 1'b0;
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
   endtask

   logic [7:0] exp_q [$];

   initial begin
      resetn = 1'b0; spi_sclk = 1'b0; spi_sdo = 1'b0; dc = 1'b0; csn = 1'b1;
      rx_ready = 1'b0; err_clr = 1'b0;
      cycles(3);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_data", rx_data, 8'h00);
      check("rst_dc", rx_dc, 1'b0);
      check("rst_level", fifo_level, 5'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      resetn = 1'b1;
      cycles(4);

      // single command byte with latency check
      dc = 1'b0; csn = 1'b0;
      cycles(6);
      send_byte(8'h2A, 2);
      cycles(2);
      csn = 1'b1;
      cycles(6);
      check("single_data", rx_data, 8'h2A);
      check("single_dc", rx_dc, 1'b0);
      check("single_level", fifo_level, 5'd1);
      check("single_ferr", frame_err, 1'b0);
      cycles(3);
      check("single_hold", rx_data, 8'h2A);
      pop_one();
      check("single_popped", fifo_level, 5'd0);
      rx_ready = 1'b1;
      cycles(3);
      check("ready_idle_level", fifo_level, 5'd0);
      rx_ready = 1'b0;

      // data burst, no csn toggle
      dc = 1'b1; csn = 1'b0;
      cycles(6);
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      cycles(2);
      csn = 1'b1;
      cycles(4);
      check("burst_level", fifo_level, 5'd4);
      exp_q = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
      foreach (exp_q[i]) begin
         check("burst_data", rx_data, exp_q[i]);
         check("burst_dc", rx_dc, 1'b1);
         pop_one();
      end
      check("burst_level0", fifo_level, 5'd0);
      check("burst_valid0", rx_valid, 1'b0);

      // fill, overflow, clear, push+pop at full
      dc = 1'b0; csn = 1'b0;
      cycles(6);
      for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
      cycles(2);
      check("full_level", fifo_level, 5'd16);
      check("full_no_ovf", overflow, 1'b0);
      send_byte(8'h10, 0);
      cycles(2);
      check("ovf_set", overflow, 1'b1);
      check("ovf_level", fifo_level, 5'd16);
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      check("ovf_clr", overflow, 1'b0);
      send_byte(8'h55, 1);
      cycles(2);
      check("pp_ovf", overflow, 1'b0);
      check("pp_level", fifo_level, 5'd16);
      check("pp_head", rx_data, 8'h01);
      cycles(2);
      csn = 1'b1;
      cycles(4);
      exp_q = {};
      for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h55);
      foreach (exp_q[i]) begin
         check("drain_data", rx_data, exp_q[i]);
         pop_one();
      end
      check("drain_level", fifo_level, 5'd0);

      // framing error: 5 bits then csn high
      csn = 1'b0;
      cycles(6);
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      cycles(3);
      csn = 1'b1;
      cycles(8);
      check("ferr_set", frame_err, 1'b1);
      check("ferr_level", fifo_level, 5'd0);
      dc = 1'b1; csn = 1'b0;
      cycles(6);
      send_byte(8'h81, 0);
      cycles(2);
      csn = 1'b1;
      cycles(4);
      check("ferr_next_data", rx_data, 8'h81);
      check("ferr_next_dc", rx_dc, 1'b1);
      check("ferr_sticky", frame_err, 1'b1);
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      check("ferr_clr", frame_err, 1'b0);
      pop_one();

      // reset in the middle of a frame
      csn = 1'b0;
      cycles(6);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
      check("mid_level2", fifo_level, 5'd2);
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", rx_valid, 1'b0);
      check("mid_rst_level", fifo_level, 5'd0);
      check("mid_rst_data", rx_data, 8'h00);
      check("mid_rst_dc", rx_dc, 1'b0);
      check("mid_rst_ovf", overflow, 1'b0);
      check("mid_rst_ferr", frame_err, 1'b0);
      cycles(3);
      resetn = 1'b1;
      cycles(6);
      send_byte(8'h3C, 0);
      cycles(2);
      check("post_rst_data", rx_data, 8'h3C);
      check("post_rst_dc", rx_dc, 1'b1);
      check("post_rst_level", fifo_level, 5'd1);
      csn = 1'b1;
      cycles(6);
      check("post_rst_ferr", frame_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
